// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// Memory-stage load/store unit: places store data on byte lanes of a 32-bit word bus,
// extracts and extends load data, and stalls the pipeline for the bus handshake.
module mem_access_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memen,
   input  logic [2:0]  memop,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        flush,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        adel,
   output logic        ades,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LBU = 3'b001;
   localparam logic [2:0] OP_LH  = 3'b010;
   localparam logic [2:0] OP_LHU = 3'b011;
   localparam logic [2:0] OP_LW  = 3'b100;
   localparam logic [2:0] OP_SB  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;
   localparam logic [2:0] OP_SW  = 3'b111;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t        state, nextState;
   logic [CW-1:0] waitCnt;
   logic [2:0]    opQ;
   logic [1:0]    laneQ;
   logic          flushQ;
   logic          isStore, misaligned, accept, ackHit, timeoutHit, flushed;
   logic [3:0]    strbNext;
   logic [31:0]   wdataNext, loadData;
   logic [7:0]    laneByte;
   logic [15:0]   laneHalf;

   assign isStore = memop[2] & (memop[1] | memop[0]);
   assign flushed = flushQ | flush;

   always_comb begin
      misaligned = 1'b0;
      case (memop)
         OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
         OP_LW, OP_SW:         misaligned = |addr[1:0];
         default:              misaligned = 1'b0;
      endcase
   end

   always_comb begin
      strbNext  = 4'b0000;
      wdataNext = 32'd0;
      case (memop)
         OP_SB: begin
            strbNext  = 4'b0001 << addr[1:0];
            wdataNext = {4{wdata[7:0]}};
         end
         OP_SH: begin
            strbNext  = addr[1] ? 4'b1100 : 4'b0011;
            wdataNext = {2{wdata[15:0]}};
         end
         OP_SW: begin
            strbNext  = 4'b1111;
            wdataNext = wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      laneByte = bus_rdata[{laneQ, 3'b000} +: 8];
      laneHalf = laneQ[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (opQ)
         OP_LB:   loadData = {{24{laneByte[7]}}, laneByte};
         OP_LBU:  loadData = {24'd0, laneByte};
         OP_LH:   loadData = {{16{laneHalf[15]}}, laneHalf};
         OP_LHU:  loadData = {16'd0, laneHalf};
         default: loadData = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   always_comb begin
      nextState  = state;
      stall      = 1'b0;
      bus_req    = 1'b0;
      adel       = 1'b0;
      ades       = 1'b0;
      accept     = 1'b0;
      ackHit     = 1'b0;
      timeoutHit = 1'b0;
      case (state)
         IDLE: begin
            if (memen) begin
               if (misaligned) begin
                  adel = ~isStore;
                  ades = isStore;
               end else if (!flush) begin
                  stall     = 1'b1;
                  accept    = 1'b1;
                  nextState = REQ;
               end
            end
         end
         REQ: begin
            bus_req = 1'b1;
            stall   = 1'b1;
            // ack outranks a timeout landing in the same cycle
            if (bus_ack) begin
               ackHit    = 1'b1;
               nextState = flushed ? IDLE : DONE;
            end else if (waitCnt == CW'(TIMEOUT - 1)) begin
               timeoutHit = 1'b1;
               nextState  = flushed ? IDLE : DONE;
            end
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
      // Combinational outputs must read inactive while reset is held.
      if (!rst) begin
         stall   = 1'b0;
         bus_req = 1'b0;
         adel    = 1'b0;
         ades    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         waitCnt   <= '0;
         rdata     <= 32'd0;
         bus_addr  <= 32'd0;
         bus_wdata <= 32'd0;
         bus_wstrb <= 4'b0000;
         bus_we    <= 1'b0;
         bus_err   <= 1'b0;
         opQ       <= 3'b000;
         laneQ     <= 2'b00;
         flushQ    <= 1'b0;
      end else begin
         bus_err <= 1'b0;
         if (state == REQ && !ackHit && !timeoutHit) waitCnt <= waitCnt + 1'b1;
         else                                         waitCnt <= '0;
         if (accept) begin
            bus_addr  <= {addr[31:2], 2'b00};
            bus_we    <= isStore;
            bus_wstrb <= strbNext;
            bus_wdata <= wdataNext;
            opQ       <= memop;
            laneQ     <= addr[1:0];
            flushQ    <= 1'b0;
         end
         if (state == REQ) begin
            if (flush) flushQ <= 1'b1;
            if (ackHit || timeoutHit) begin
               bus_addr  <= 32'd0;
               bus_we    <= 1'b0;
               bus_wstrb <= 4'b0000;
               bus_wdata <= 32'd0;
               flushQ    <= 1'b0;
               // a flushed instruction leaves rdata untouched
               if (!flushed) begin
                  if (ackHit && !(opQ[2] & (opQ[1] | opQ[0]))) rdata <= loadData;
                  if (timeoutHit) begin
                     rdata   <= 32'd0;
                     bus_err <= 1'b1;
                  end
               end
            end
         end
      end
   end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum REQ cycles waiting for bus_ack before bus_err is raised.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 memen  input  1  memory-stage instruction is a load/store; held stable by the pipeline while stall=1.
REQ-005 memop  input  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
REQ-006 addr  input  32  effective address (the memory-stage ALU result).
REQ-007 wdata  input  32  store data (the memory-stage write-data value), right-aligned.
REQ-008 flush  input  1  exception flush of the memory-stage instruction.
REQ-009 rdata  output  32  extended load result, valid in DONE.
REQ-010 stall  output  1  freezes the pipeline.
REQ-011 adel / ades  output  1 each  load / store address-misalignment flags.
REQ-012 bus_err  output  1  one-cycle pulse on ack timeout.
REQ-013 bus_req, bus_we  output  1 each  bus request and write enable.
REQ-014 bus_addr  output  32  word-aligned address; bus_wstrb output 4; bus_wdata output 32.
REQ-015 bus_ack  input  1; bus_rdata  input  32.

Function
REQ-016 States: IDLE, REQ, DONE.
REQ-017 Misalignment, combinational in IDLE: halfword ops with addr[0]=1, or LW/SW with addr[1:0]!=0; raises adel (loads) or ades (stores); no bus transaction; stall=0.
REQ-018 IDLE with memen=1, flush=0, aligned: stall=1 combinationally; next state REQ; bus_addr={addr[31:2],2'b00}, bus_we, bus_wstrb and bus_wdata registered at that edge.
REQ-019 Store lanes: SB replicates byte x4, wstrb=0001<<addr[1:0]; SH replicates halfword x2, wstrb=0011 (addr[1]=0) or 1100; SW wstrb=1111. Loads drive wstrb=0000.
REQ-020 REQ: bus_req=1, all bus outputs held stable, stall=1, wait counter increments each cycle.
REQ-021 REQ with bus_ack=1: load data extracted from bus_rdata by addr[1:1:0] lane (sign-extended for LB/LH, zero-extended for LBU/LHU, whole word for LW) is registered into rdata; next state DONE; counter cleared.
REQ-022 DONE: stall=0, bus_req=0, rdata valid for exactly this cycle; next state IDLE unconditionally; a new memen is not accepted in DONE.
REQ-023 Timeout: counter reaches TIMEOUT in REQ without ack -> bus_err pulses one cycle, bus_req drops, next state DONE, rdata=0.
REQ-024 flush in IDLE: request not started, stall=0. flush during REQ: bus_req held until ack (bus not abortable), stall stays 1, then IDLE directly with rdata unchanged.
REQ-025 Ack in the same cycle as timeout: ack wins, no bus_err.
REQ-026 memen=0 in IDLE: all outputs inactive, stall=0.

Reset
REQ-027 rst=0 asynchronously forces IDLE, counter=0, rdata=0, bus_addr/bus_wdata=0, bus_wstrb=0, bus_we=0; bus_req, stall, bus_err, adel, ades read 0.
REQ-028 Reset mid-REQ abandons the transaction; the first post-reset cycle is IDLE.

Verification
REQ-029 LB, addr=0x1003, bus_rdata=0x80FF_1234, ack 2 cycles after REQ -> bus_addr 0x1000, stall high 3 cycles, rdata 0xFFFF_FF80 in DONE.
REQ-030 SH, addr=0x2002, wdata=0x0000_BEEF, immediate ack -> bus_we=1, bus_wstrb=1100, bus_wdata=0xBEEF_BEEF, one REQ cycle.
REQ-031 LW, addr=0x0000_0006 -> adel=1, stall=0, bus_req never asserted.
REQ-032 TIMEOUT=4, LHU without ack -> bus_req high 4 cycles, bus_err one pulse, rdata=0, then IDLE.
REQ-033 flush asserted in REQ cycle 1, ack in cycle 3 -> stall deasserts after ack, no DONE cycle, rdata unchanged.
REQ-034 rst low during REQ -> bus_req=0 and stall=0 immediately, IDLE after release.
